// File: rtl/riscv_fetch_pkg.sv
// Shared configuration and helper types for the instruction fetch stage.
package riscv_fetch_pkg;

    localparam int XLEN          = 32;
    localparam int IMEM_ADDR_BIT = 12;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_BYTES   = 32'd4;

    // Source of the next program counter value.
    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_SEQ      = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

    // A target is misaligned when it is not on a 4-byte instruction boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/riscv_ifid_reg.sv
// IF/ID pipeline register: load, hold, drain and flush with NOP fill.
module riscv_ifid_reg
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_flush,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc
);

    logic            valid_r;
    logic [XLEN-1:0] instr_r;
    logic [XLEN-1:0] pc_r;

    // Entry update with priority reset > flush > load > drain > hold.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            pc_r    <= RESET_PC;
        end else if (i_flush) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            pc_r    <= pc_r;
        end else if (i_load) begin
            valid_r <= 1'b1;
            instr_r <= i_instr;
            pc_r    <= i_pc;
        end else if (i_drain) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            pc_r    <= pc_r;
        end else begin
            valid_r <= valid_r;
            instr_r <= instr_r;
            pc_r    <= pc_r;
        end
    end

    assign o_valid = valid_r;
    assign o_instr = instr_r;
    assign o_pc    = pc_r;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: program counter, next-PC selection, misalign
// tracking and the IF/ID register feeding decode.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_fetch_en,
    output logic [IMEM_ADDR_BIT-3:0] o_imem_addr,
    input  logic [XLEN-1:0]          i_imem_data,
    input  logic                     i_redirect,
    input  logic [XLEN-1:0]          i_redirect_pc,
    output logic                     o_if_valid,
    input  logic                     i_id_ready,
    output logic [XLEN-1:0]          o_if_instr,
    output logic [XLEN-1:0]          o_if_pc,
    output logic [XLEN-1:0]          o_if_pc4,
    output logic                     o_misalign
);

    logic [XLEN-1:0] pc_r;
    logic            misalign_r;
    logic            advance_s;
    logic            drain_s;
    pc_sel_e         pc_sel_s;
    logic [XLEN-1:0] pc_next_s;
    logic            if_valid_s;
    logic [XLEN-1:0] if_instr_s;
    logic [XLEN-1:0] if_pc_s;

    // A new word may be captured only when fetching is allowed, the PC is
    // aligned and the IF/ID slot is empty or being consumed this cycle.
    assign advance_s = i_fetch_en & ~misalign_r & (~if_valid_s | i_id_ready);
    assign drain_s   = ~advance_s & if_valid_s & i_id_ready;

    // Choose the next-PC source; redirect outranks sequential advance.
    always_comb begin
        pc_sel_s = PC_SEL_HOLD;
        if (i_redirect) begin
            pc_sel_s = PC_SEL_REDIRECT;
        end else if (advance_s) begin
            pc_sel_s = PC_SEL_SEQ;
        end else begin
            pc_sel_s = PC_SEL_HOLD;
        end
    end

    // Next-PC mux; sequential increment wraps naturally at 2^XLEN.
    always_comb begin
        pc_next_s = pc_r;
        case (pc_sel_s)
            PC_SEL_HOLD:     pc_next_s = pc_r;
            PC_SEL_SEQ:      pc_next_s = pc_r + INSTR_BYTES;
            PC_SEL_REDIRECT: pc_next_s = i_redirect_pc;
            default:         pc_next_s = pc_r;
        endcase
    end

    // PC register and sticky misalign flag, cleared only by redirect or reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            pc_r       <= RESET_PC;
            misalign_r <= 1'b0;
        end else if (i_redirect) begin
            pc_r       <= pc_next_s;
            misalign_r <= is_misaligned(i_redirect_pc);
        end else begin
            pc_r       <= pc_next_s;
            misalign_r <= misalign_r;
        end
    end

    riscv_ifid_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_flush (i_redirect),
        .i_load  (advance_s),
        .i_drain (drain_s),
        .i_instr (i_imem_data),
        .i_pc    (pc_r),
        .o_valid (if_valid_s),
        .o_instr (if_instr_s),
        .o_pc    (if_pc_s)
    );

    // Upper PC bits beyond the IMEM window are dropped, so the address wraps.
    assign o_imem_addr = pc_r[IMEM_ADDR_BIT-1:2];
    assign o_if_valid  = if_valid_s;
    assign o_if_instr  = if_instr_s;
    assign o_if_pc     = if_pc_s;
    assign o_if_pc4    = if_pc_s + INSTR_BYTES;
    assign o_misalign  = misalign_r;

endmodule
